// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: CPU (m0) has priority,
// the debug/loader master (m1) is promoted after STARVE_LIMIT denied cycles.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wen,
    input  logic        m0_lock,
    input  logic [10:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    input  logic        m1_req,
    input  logic        m1_wen,
    input  logic        m1_lock,
    input  logic [10:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] rdata,
    output logic        mem_wren,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_q
);

    localparam int unsigned CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          promote;
    logic          rd0_q, rd1_q;

    // Grants are combinational, so reset must mask them directly.
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        state_nxt = IDLE;
        promote   = (starve_cnt == LIMIT) && m1_req;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (m0_req && !promote) m0_gnt = 1'b1;
                    else if (m1_req)        m1_gnt = 1'b1;
                end
                OWN0:    m0_gnt = m0_req;
                OWN1:    m1_gnt = m1_req;
                default: ;
            endcase
        end
        if (m0_gnt)                       state_nxt = m0_lock ? OWN0 : IDLE;
        else if (m1_gnt)                  state_nxt = m1_lock ? OWN1 : IDLE;
        else if (state == OWN0 && m0_lock) state_nxt = OWN0;
        else if (state == OWN1 && m1_lock) state_nxt = OWN1;
    end

    always_comb begin
        mem_wren = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (m0_gnt) begin
            mem_wren = m0_wen;
            mem_addr = m0_addr;
            mem_data = m0_wdata;
        end else if (m1_gnt) begin
            mem_wren = m1_wen;
            mem_addr = m1_addr;
            mem_data = m1_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            rd0_q      <= 1'b0;
            rd1_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!m1_req || m1_gnt)      starve_cnt <= '0;
            else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
            rd0_q <= m0_gnt & ~m0_wen;
            rd1_q <= m1_gnt & ~m1_wen;
        end
    end

    assign m0_rvalid = rd0_q;
    assign m1_rvalid = rd1_q;
    assign rdata     = mem_q;

endmodule
